mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single memory bus port of the multi-cycle RV32I core between two requesters.
- Requester IF: instruction fetch, issued in FETCH_S1.
- Requester D: load/store, issued in MEM_S4.
- Serialises accesses, holds each access until the memory acknowledges, returns read data and a one-cycle done pulse to the owner, and aborts accesses that exceed a timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 64, maximum cycles waiting for mem_ack. 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- if_req  input  1  fetch request; held high until if_done.
- if_addr  input  ADDR_W  fetch address.
- d_req  input  1  data request; held high until d_done.
- d_addr  input  ADDR_W  data address.
- d_wren  input  1  1 = store, 0 = load.
- d_be  input  4  byte enables for the store.
- d_wdata  input  DATA_W  store data.
- if_done  output  1  one-cycle pulse; IF access complete.
- d_done  output  1  one-cycle pulse; D access complete.
- rsp_rdata  output  DATA_W  read data; valid while either done is high.
- rsp_err  output  1  timeout flag; valid while either done is high.
- mem_req  output  1  memory access request.
- mem_addr  output  ADDR_W  memory address.
- mem_wren  output  1  memory write enable.
- mem_be  output  4  memory byte enables.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid with mem_ack.
- mem_ack  input  1  access complete; may assert in any cycle while mem_req is high.

Behaviour:
- Reset values: all outputs 0; state IDLE; owner register = IF; last_grant = D; timeout counter 0.
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If only one request is high, grant it.
  - If both are high, grant the requester not in last_grant (round-robin).
  - On grant: latch addr/wren/be/wdata into the mem_* output registers (IF: wren=0, be=4'hF, wdata=0); set owner; update last_grant; next state ACCESS.
- ACCESS:
  - mem_req=1; mem_* outputs held stable.
  - On mem_ack: capture mem_rdata into rsp_rdata (stores capture 0); rsp_err=0; next state RESP.
  - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: rsp_rdata=0, rsp_err=1, next state RESP.
  - Counter increments every ACCESS cycle and clears on leaving ACCESS.
- RESP:
  - Owner's done=1 for exactly one cycle; mem_req=0.
  - Requests are ignored in RESP, so a request still high in the done cycle is not re-granted.
  - Next state IDLE.
  - rsp_rdata/rsp_err hold until the next RESP.
- Latency: request sampled at edge 0 -> mem_req high cycle 1 -> ack in cycle 1 -> done cycle 2 -> IDLE cycle 3, ready to grant. Minimum 3 cycles per access; each wait state adds 1 cycle.
- Boundary conditions:
  - mem_ack outside ACCESS is ignored.
  - mem_ack in the same cycle as the timeout: ack wins, rsp_err=0.
  - A request dropped during ACCESS does not cancel the access; done still pulses.
  - Only one access is outstanding at a time; never two done pulses in the same cycle.
  - rst high mid-access: all registers return to reset values at that edge; mem_req=0 the next cycle; no done pulse.
  - Timeout counter is at least clog2(TIMEOUT_CYCLES+1) bits and never wraps.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_if_grants [31:0], perf_d_grants [31:0], perf_wait_cycles [31:0].
  - Grant counters increment on each grant to their requester.
  - perf_wait_cycles increments in every cycle where a request is high but not being serviced (IDLE/RESP with the opposite owner, or ACCESS/RESP for the other requester).
  - All counters saturate at 32'hFFFF_FFFF and clear on rst.
- Not defined: these ports and their logic are absent; all other behaviour is unchanged.

Test Plan:
- if_req=1, if_addr=0x100, mem_ack in the first ACCESS cycle with mem_rdata=0x00500093 -> mem_req high 1 cycle with mem_addr=0x100, mem_wren=0; if_done pulses cycle 2 with rsp_rdata=0x00500093, rsp_err=0.
- d_req=1, d_wren=1, d_addr=0x2004, d_be=4'h3, d_wdata=0xA5A5, mem_ack after 3 wait cycles -> mem_req high 4 cycles with stable outputs; d_done 1 cycle; rsp_rdata=0.
- if_req and d_req both high from reset, held high, with zero-wait ack -> grant order IF, D, IF, D; each done is exactly 1 cycle; no grant ever occurs in the RESP cycle.
- TIMEOUT_CYCLES=4, d_req load, no mem_ack -> mem_req high exactly 4 cycles; d_done with rsp_err=1, rsp_err=1 and rsp_rdata=0; ack arriving on cycle 4 instead gives rsp_err=0.
- rst asserted in the 2nd ACCESS cycle of an IF access -> mem_req=0 next cycle, no if_done, all outputs 0; a new d_req after reset is granted normally.
- With MEM_ARB_PERF_CNT_EN: 3 IF and 2 D accesses, both requesting in one contested window -> perf_if_grants=3, perf_d_grants=2; perf_wait_cycles equals the count of cycles the losing request waited.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing the RV32I core's single memory port between fetch and load/store.
// Define MEM_ARB_PERF_CNT_EN to add grant and wait-cycle performance counters.
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wren,
  input  logic [3:0]        d_be,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              if_done,
  output logic              d_done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_wait_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
  localparam int   CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wren_q, mem_wren_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;

  logic grant_if_s, grant_d_s, timeout_s;

  // On contention the requester that was not granted last wins.
  assign grant_if_s = if_req && (!d_req || (last_q == OWN_D));
  assign grant_d_s  = d_req && (!if_req || (last_q == OWN_IF));
  assign timeout_s  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      last_q      <= OWN_D;
      cnt_q       <= {CNT_W{1'b0}};
      mem_req_q   <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wren_q  <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= {DATA_W{1'b0}};
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wren_q  <= mem_wren_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
    end
  end

  // Next-state logic; requests are only considered in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = (grant_if_s || grant_d_s) ? S_ACCESS : S_IDLE;
      S_ACCESS: state_d = (mem_ack || timeout_s) ? S_RESP : S_ACCESS;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = {CNT_W{1'b0}};
    mem_addr_d  = mem_addr_q;
    mem_wren_d  = mem_wren_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_if_s) begin
          owner_d     = OWN_IF;
          last_d      = OWN_IF;
          mem_addr_d  = if_addr;
          mem_wren_d  = 1'b0;
          mem_be_d    = 4'hF;
          mem_wdata_d = {DATA_W{1'b0}};
        end else if (grant_d_s) begin
          owner_d     = OWN_D;
          last_d      = OWN_D;
          mem_addr_d  = d_addr;
          mem_wren_d  = d_wren;
          mem_be_d    = d_be;
          mem_wdata_d = d_wdata;
        end else begin
          owner_d = owner_q;
        end
      end
      S_ACCESS: begin
        // Ack beats a coincident timeout; the counter saturates rather than wraps.
        if (mem_ack) begin
          rsp_rdata_d = mem_wren_q ? {DATA_W{1'b0}} : mem_rdata;
          rsp_err_d   = 1'b0;
        end else if (timeout_s) begin
          rsp_rdata_d = {DATA_W{1'b0}};
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = (cnt_q != CNT_MAX) ? (cnt_q + CNT_W'(1)) : cnt_q;
        end
      end
      default: begin
        owner_d = owner_q;
      end
    endcase
    mem_req_d = (state_d == S_ACCESS);
    if_done_d = (state_d == S_RESP) && (owner_d == OWN_IF);
    d_done_d  = (state_d == S_RESP) && (owner_d == OWN_D);
  end

  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wren  = mem_wren_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants_q, perf_if_grants_d;
  logic [31:0] perf_d_grants_q, perf_d_grants_d;
  logic [31:0] perf_wait_cycles_q, perf_wait_cycles_d;
  logic        if_wait_s, d_wait_s;

  // A request waits when it loses arbitration in IDLE or another owner holds the bus.
  assign if_wait_s = if_req && (((state_q == S_IDLE) && !grant_if_s) ||
                                ((state_q != S_IDLE) && (owner_q == OWN_D)));
  assign d_wait_s  = d_req && (((state_q == S_IDLE) && !grant_d_s) ||
                               ((state_q != S_IDLE) && (owner_q == OWN_IF)));

  // Saturating counter next values.
  always_comb begin
    perf_if_grants_d   = perf_if_grants_q;
    perf_d_grants_d    = perf_d_grants_q;
    perf_wait_cycles_d = perf_wait_cycles_q;
    if ((state_q == S_IDLE) && grant_if_s && (perf_if_grants_q != 32'hFFFF_FFFF)) begin
      perf_if_grants_d = perf_if_grants_q + 32'd1;
    end else begin
      perf_if_grants_d = perf_if_grants_q;
    end
    if ((state_q == S_IDLE) && !grant_if_s && grant_d_s && (perf_d_grants_q != 32'hFFFF_FFFF)) begin
      perf_d_grants_d = perf_d_grants_q + 32'd1;
    end else begin
      perf_d_grants_d = perf_d_grants_q;
    end
    if ((if_wait_s || d_wait_s) && (perf_wait_cycles_q != 32'hFFFF_FFFF)) begin
      perf_wait_cycles_d = perf_wait_cycles_q + 32'd1;
    end else begin
      perf_wait_cycles_d = perf_wait_cycles_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_grants_q   <= 32'd0;
      perf_d_grants_q    <= 32'd0;
      perf_wait_cycles_q <= 32'd0;
    end else begin
      perf_if_grants_q   <= perf_if_grants_d;
      perf_d_grants_q    <= perf_d_grants_d;
      perf_wait_cycles_q <= perf_wait_cycles_d;
    end
  end

  assign perf_if_grants   = perf_if_grants_q;
  assign perf_d_grants    = perf_d_grants_q;
  assign perf_wait_cycles = perf_wait_cycles_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a round-level model predicts grant order, bus contents and
// responses; a monitor checks them as the DUT presents them while a memory responder injects wait states.
module tb_mem_bus_arbiter;
  localparam int T = 4;

  typedef struct {
    logic [31:0] addr;
    logic        wren;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          len;
  } acc_t;
  typedef struct {
    int          w;
    logic [31:0] rdata;
  } plan_t;
  typedef struct {
    bit          who_d;
    logic [31:0] rdata;
    bit          err;
  } rsp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_wren = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0, mem_rdata = 32'd0;
  logic [3:0]  d_be = 4'd0;
  logic        if_done, d_done, rsp_err, mem_req, mem_wren;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants, perf_d_grants, perf_wait_cycles;
`endif

  int checks = 0, failures = 0;
  acc_t  exp_acc[$];
  plan_t plan_q[$];
  rsp_t  exp_rsp[$];
  bit    last_d = 1'b1;
  bit    skip_fall = 1'b0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .d_req(d_req), .d_addr(d_addr), .d_wren(d_wren), .d_be(d_be), .d_wdata(d_wdata),
    .if_done(if_done), .d_done(d_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
    .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks after the planned number of wait cycles, stray acks while idle.
  initial begin
    bit active = 1'b0;
    int wcnt = 0;
    plan_t p;
    p.w = 1000;
    p.rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!active) begin
          active = 1'b1;
          wcnt = 0;
          if (plan_q.size() != 0) p = plan_q.pop_front();
          else p.w = 1000;
        end
        mem_ack   = (wcnt == p.w);
        mem_rdata = mem_ack ? p.rdata : $urandom;
        wcnt++;
      end else begin
        active    = 1'b0;
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: checks bus contents, access length and responses against the scoreboard queues.
  initial begin
    bit prev_req = 1'b0, prev_done = 1'b0;
    int hi = 0;
    acc_t cur;
    rsp_t r;
    cur.addr = 32'd0; cur.wren = 1'b0; cur.be = 4'd0; cur.wdata = 32'd0; cur.len = 0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (exp_acc.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_access: got mem_req=1 addr %h expected no access", mem_addr);
        end else begin
          cur = exp_acc.pop_front();
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_wren", 32'(mem_wren), 32'(cur.wren));
          chk("mem_be", 32'(mem_be), 32'(cur.be));
          chk("mem_wdata", mem_wdata, cur.wdata);
        end
        hi = 1;
      end else if (mem_req) begin
        chk("stable_addr", mem_addr, cur.addr);
        chk("stable_wren", 32'(mem_wren), 32'(cur.wren));
        chk("stable_be", 32'(mem_be), 32'(cur.be));
        chk("stable_wdata", mem_wdata, cur.wdata);
        hi++;
      end else if (prev_req) begin
        if (!skip_fall) begin
          chk("access_len", 32'(hi), 32'(cur.len));
          chk("done_after_access", 32'(if_done | d_done), 32'd1);
        end
        hi = 0;
      end
      if (if_done || d_done) begin
        chk("two_dones", 32'(if_done & d_done), 32'd0);
        chk("req_in_resp", 32'(mem_req), 32'd0);
        if (exp_rsp.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got if_done=%0b d_done=%0b expected none", if_done, d_done);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_owner_d", 32'(d_done), 32'(r.who_d));
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(r.err));
        end
      end
      if (prev_done) chk("req_after_resp", 32'(mem_req), 32'd0);
      prev_req  = mem_req;
      prev_done = if_done | d_done;
    end
  end

  // Model one access: expected bus contents, memory plan and response.
  task automatic push_access(input bit is_d, input logic [31:0] addr, input bit wr,
                             input logic [3:0] be, input logic [31:0] wd, input int w,
                             input logic [31:0] rv);
    acc_t a;
    plan_t p;
    rsp_t r;
    a.addr  = addr;
    a.wren  = is_d ? wr : 1'b0;
    a.be    = is_d ? be : 4'hF;
    a.wdata = is_d ? wd : 32'd0;
    a.len   = (w < T) ? w + 1 : T;
    p.w     = w;
    p.rdata = rv;
    r.who_d = is_d;
    r.err   = (w >= T);
    r.rdata = (r.err || a.wren) ? 32'd0 : rv;
    exp_acc.push_back(a);
    plan_q.push_back(p);
    exp_rsp.push_back(r);
  endtask

  // One round: raise the chosen requests together, predict round-robin order, wait for all dones.
  task automatic run_round(input bit use_if, input bit use_d, input logic [31:0] ia,
                           input logic [31:0] da, input bit wr, input logic [3:0] dbe,
                           input logic [31:0] wd, input int wi, input int wdw,
                           input logic [31:0] ri, input logic [31:0] rdd, input bit drop);
    bit d_first;
    int n, seen;
    n = int'(use_if) + int'(use_d);
    d_first = (use_if && use_d) ? !last_d : use_d;
    for (int k = 0; k < 2; k++) begin
      bit is_d;
      is_d = (k == 0) ? d_first : !d_first;
      if (is_d && use_d) push_access(1'b1, da, wr, dbe, wd, wdw, rdd);
      else if (!is_d && use_if) push_access(1'b0, ia, 1'b0, 4'hF, 32'd0, wi, ri);
    end
    last_d = (n == 2) ? !d_first : use_d;
    @(negedge clk);
    if_req = use_if; if_addr = ia;
    d_req = use_d; d_addr = da; d_wren = wr; d_be = dbe; d_wdata = wd;
    seen = 0;
    for (int cyc = 0; cyc < 40 && seen < n; cyc++) begin
      @(negedge clk);
      if (cyc == 0 && n == 1) chk("grant_latency", 32'(mem_req), 32'd1);
      if (cyc == 0 && drop && n == 1) begin
        if_req = 1'b0;
        d_req = 1'b0;
      end
      if (if_done) begin if_req = 1'b0; seen++; end
      if (d_done) begin d_req = 1'b0; seen++; end
    end
    chk("round_complete", 32'(seen), 32'(n));
    if_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_done", 32'({if_done, d_done}), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_err", 32'(rsp_err), 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_be", 32'(mem_be), 32'd0);
    rst = 1'b0;

    run_round(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 0, 0, 32'h0050_0093, 32'h0, 1'b0);
    run_round(1'b0, 1'b1, 32'h0, 32'h2004, 1'b1, 4'h3, 32'hA5A5, 0, 3, 32'h0, 32'hDEAD_BEEF, 1'b0);
    run_round(1'b0, 1'b1, 32'h0, 32'h3000, 1'b0, 4'hF, 32'h0, 0, 6, 32'h0, 32'h1234_5678, 1'b0);
    run_round(1'b0, 1'b1, 32'h0, 32'h3004, 1'b0, 4'hF, 32'h0, 0, 3, 32'h0, 32'h8765_4321, 1'b0);
    run_round(1'b1, 1'b1, 32'h200, 32'h4000, 1'b0, 4'hF, 32'h0, 0, 0, 32'h1111, 32'h2222, 1'b0);
    run_round(1'b1, 1'b0, 32'h204, 32'h0, 1'b0, 4'h0, 32'h0, 1, 0, 32'h3333, 32'h0, 1'b1);
    run_round(1'b1, 1'b1, 32'h208, 32'h4008, 1'b1, 4'h1, 32'h77, 0, 0, 32'h4444, 32'h5555, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int pat;
      pat = $urandom_range(0, 2);
      run_round(pat != 1, pat != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 5),
                $urandom_range(0, 5), $urandom, $urandom,
                (pat != 2) && ($urandom_range(0, 3) == 0));
    end

    run_round(1'b0, 1'b1, 32'h0, 32'h5000, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Reset in the second ACCESS cycle of a fetch.
    skip_fall = 1'b1;
    push_access(1'b0, 32'h300, 1'b0, 4'hF, 32'h0, 50, 32'h9999);
    void'(exp_rsp.pop_back());
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    chk("rst_test_access", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_no_done", 32'({if_done, d_done}), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    if_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    skip_fall = 1'b0;
    plan_q.delete();
    last_d = 1'b1;
    run_round(1'b0, 1'b1, 32'h0, 32'h6000, 1'b0, 4'hF, 32'h0, 0, 1, 32'h0, 32'h0BAD_C0DE, 1'b0);

    repeat (4) @(negedge clk);
    chk("acc_drained", 32'(exp_acc.size()), 32'd0);
    chk("rsp_drained", 32'(exp_rsp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
